// File: rtl/circulant_transpose_ctrl_if.sv
// -----------------------------------------------------------------------------
// circulant_transpose_ctrl_if
//
// Bundles every non-clock signal of the circulant transpose sequencer:
//   producer stream : in_data, in_valid, in_ready
//   consumer stream : out_data, out_valid, out_ready, out_last_row, out_last
//   store write port: mem_write_en, mem_write_row, mem_write_col, mem_data_in
//   store read port : mem_read_en, mem_read_row, mem_read_col, mem_data_out
//
// modport master : the sequencer's view (drives in_ready, out_*, mem_* strobes)
// modport slave  : the surroundings' view (producer, consumer and store)
// -----------------------------------------------------------------------------
interface circulant_transpose_ctrl_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8
) ();
    localparam int AW = $clog2(N);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last_row;
    logic              out_last;

    logic              mem_write_en;
    logic [AW-1:0]     mem_write_row;
    logic [AW-1:0]     mem_write_col;
    logic [DATA_W-1:0] mem_data_in;

    logic              mem_read_en;
    logic [AW-1:0]     mem_read_row;
    logic [AW-1:0]     mem_read_col;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        input  in_data, in_valid, out_ready, mem_data_out,
        output in_ready, out_data, out_valid, out_last_row, out_last,
        output mem_write_en, mem_write_row, mem_write_col, mem_data_in,
        output mem_read_en, mem_read_row, mem_read_col
    );

    modport slave (
        output in_data, in_valid, out_ready, mem_data_out,
        input  in_ready, out_data, out_valid, out_last_row, out_last,
        input  mem_write_en, mem_write_row, mem_write_col, mem_data_in,
        input  mem_read_en, mem_read_row, mem_read_col
    );
endinterface

// File: rtl/circulant_transpose_ctrl.sv
// -----------------------------------------------------------------------------
// circulant_transpose_ctrl
//
// Accepts one NxN matrix as a row-major valid/ready stream, writes it into the
// circulant store, then drains the transposed matrix row-major. The store has a
// one-cycle registered read; returning data lands in a 2-entry skid FIFO (with
// bypass when empty) so downstream backpressure never loses an element.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   xpose_sel  (only with XPOSE_SELECT_EN) 1 = transposed, 0 = pass-through,
//              sampled on the FILL->DRAIN transition
//   bus        circulant_transpose_ctrl_if.master (streams + store ports)
//
// Build option: define XPOSE_SELECT_EN to add xpose_sel; otherwise the output
// is always the transpose.
// -----------------------------------------------------------------------------
module circulant_transpose_ctrl #(
    parameter int N      = 4,
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef XPOSE_SELECT_EN
    input  logic xpose_sel,
`endif
    circulant_transpose_ctrl_if.master bus
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic [AW-1:0]     rd_i_q, rd_i_d, rd_j_q, rd_j_d;
    logic              rd_done_q, rd_done_d;
    // Read issued last cycle: its data is on mem_data_out this cycle.
    logic              fl_valid_q, fl_valid_d;
    logic              fl_last_row_q, fl_last_row_d, fl_last_q, fl_last_d;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic              fifo_lr_q [2];
    logic              fifo_lr_d [2];
    logic              fifo_last_q [2];
    logic              fifo_last_d [2];
    logic              head_q, head_d, tail_q, tail_d;
    logic [1:0]        count_q, count_d;

    logic wr_fire, rd_issue, out_fire, head_valid, head_last, fifo_push, fifo_pop;
    logic xpose_now;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FILL;
            S_FILL:  if (wr_fire && wr_row_q == LAST && wr_col_q == LAST) state_d = S_DRAIN;
            S_DRAIN: if (out_fire && head_last) state_d = S_FILL;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus.in_ready = (state_q == S_FILL);
        wr_fire      = (state_q == S_FILL) && bus.in_valid;
        // In-flight read plus skid occupancy bounds outstanding data to 2.
        rd_issue     = (state_q == S_DRAIN) && !rd_done_q
                       && (({1'b0, fl_valid_q} + count_q) < 2'd2);

        bus.mem_write_en  = wr_fire;
        bus.mem_write_row = wr_fire ? wr_row_q : '0;
        bus.mem_write_col = wr_fire ? wr_col_q : '0;
        bus.mem_data_in   = wr_fire ? bus.in_data : '0;

        bus.mem_read_en  = rd_issue;
        bus.mem_read_row = '0;
        bus.mem_read_col = '0;
        if (rd_issue) begin
            bus.mem_read_row = xpose_now ? rd_j_q : rd_i_q;
            bus.mem_read_col = xpose_now ? rd_i_q : rd_j_q;
        end

        // Head is the oldest FIFO entry, or the returning read when the FIFO is empty.
        head_valid       = 1'b0;
        head_last        = 1'b0;
        bus.out_data     = '0;
        bus.out_last_row = 1'b0;
        if (count_q != 2'd0) begin
            head_valid       = 1'b1;
            bus.out_data     = fifo_data_q[head_q];
            bus.out_last_row = fifo_lr_q[head_q];
            head_last        = fifo_last_q[head_q];
        end else if (fl_valid_q) begin
            head_valid       = 1'b1;
            bus.out_data     = bus.mem_data_out;
            bus.out_last_row = fl_last_row_q;
            head_last        = fl_last_q;
        end
        bus.out_valid = head_valid;
        bus.out_last  = head_last;
        out_fire      = head_valid && bus.out_ready;
    end

    // ---------------- counters and skid FIFO ----------------
    always_comb begin
        wr_row_d      = wr_row_q;
        wr_col_d      = wr_col_q;
        rd_i_d        = rd_i_q;
        rd_j_d        = rd_j_q;
        rd_done_d     = rd_done_q;
        fl_valid_d    = rd_issue;
        fl_last_row_d = (rd_j_q == LAST);
        fl_last_d     = (rd_i_q == LAST) && (rd_j_q == LAST);
        fifo_data_d   = fifo_data_q;
        fifo_lr_d     = fifo_lr_q;
        fifo_last_d   = fifo_last_q;
        head_d        = head_q;
        tail_d        = tail_q;

        // Counters wrap modulo N, so the final write leaves both at zero.
        if (wr_fire) begin
            wr_col_d = wr_col_q + AW'(1);
            if (wr_col_q == LAST) wr_row_d = wr_row_q + AW'(1);
        end
        if (rd_issue) begin
            rd_j_d = rd_j_q + AW'(1);
            if (rd_j_q == LAST) begin
                rd_i_d = rd_i_q + AW'(1);
                if (rd_i_q == LAST) rd_done_d = 1'b1;
            end
        end
        if (state_q == S_DRAIN && state_d == S_FILL) rd_done_d = 1'b0;

        // Returning data is captured unless it is consumed straight through.
        fifo_pop  = out_fire && (count_q != 2'd0);
        fifo_push = fl_valid_q && !(out_fire && count_q == 2'd0);
        if (fifo_push) begin
            fifo_data_d[tail_q] = bus.mem_data_out;
            fifo_lr_d[tail_q]   = fl_last_row_q;
            fifo_last_d[tail_q] = fl_last_q;
            tail_d              = ~tail_q;
        end
        if (fifo_pop) head_d = ~head_q;
        count_d = count_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row_q      <= '0;
            wr_col_q      <= '0;
            rd_i_q        <= '0;
            rd_j_q        <= '0;
            rd_done_q     <= 1'b0;
            fl_valid_q    <= 1'b0;
            fl_last_row_q <= 1'b0;
            fl_last_q     <= 1'b0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            count_q       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_lr_q[i]   <= 1'b0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            wr_row_q      <= wr_row_d;
            wr_col_q      <= wr_col_d;
            rd_i_q        <= rd_i_d;
            rd_j_q        <= rd_j_d;
            rd_done_q     <= rd_done_d;
            fl_valid_q    <= fl_valid_d;
            fl_last_row_q <= fl_last_row_d;
            fl_last_q     <= fl_last_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
                fifo_lr_q[i]   <= fifo_lr_d[i];
                fifo_last_q[i] <= fifo_last_d[i];
            end
        end
    end

    // ---------------- read-orientation select ----------------
`ifdef XPOSE_SELECT_EN
    logic xpose_q, xpose_d;

    always_comb begin
        xpose_d = xpose_q;
        if (state_q == S_FILL && state_d == S_DRAIN) xpose_d = xpose_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xpose_q <= 1'b1;
        else        xpose_q <= xpose_d;
    end

    assign xpose_now = xpose_q;
`else
    assign xpose_now = 1'b1;
`endif

endmodule

// File: tb/tb_circulant_transpose_ctrl.sv
`timescale 1ns/1ps
module tb_circulant_transpose_ctrl;
    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int AW     = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    circulant_transpose_ctrl_if #(.N(N), .DATA_W(DATA_W)) bus ();
`ifdef XPOSE_SELECT_EN
    logic xpose_sel = 1'b1;
`endif

    circulant_transpose_ctrl #(.N(N), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef XPOSE_SELECT_EN
        .xpose_sel (xpose_sel),
`endif
        .bus   (bus)
    );

    // Logical store with a one-cycle registered read.
    logic [DATA_W-1:0] store [N][N];
    always @(posedge clk) begin
        if (bus.mem_write_en) store[bus.mem_write_row][bus.mem_write_col] <= bus.mem_data_in;
        if (bus.mem_read_en)  bus.mem_data_out <= store[bus.mem_read_row][bus.mem_read_col];
    end

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              lr;
        logic              last;
    } out_t;

    out_t                       exp_q[$];
    logic [2*AW+DATA_W-1:0]     exp_wr[$];
    out_t                       e_out;
    logic [2*AW+DATA_W-1:0]     e_wr;

    int cyc = 0;
    int out_cnt = 0, done_cnt = 0, issued = 0, accepted = 0, max_out = 0;
    int overlap = 0, drain_viol = 0;
    int last_wr_cyc = 0, first_rd_cyc = 0, first_ov_cyc = 0, first_out_cyc = 0, last_out_cyc = 0;
    int after_last_cyc = -10;
    bit in_drain = 0, rd_seen = 0, ov_seen = 0, out_seen = 0;
    int ready_mode = 0, stall_cnt = 0;

    always @(posedge clk) cyc++;

    // Consumer: always ready, or random, with an optional forced stall window.
    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            bus.out_ready = 1'b0;
            stall_cnt--;
        end else if (ready_mode == 0) bus.out_ready = 1'b1;
        else bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: mid-cycle, inputs and outputs are settled for the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (bus.mem_write_en && bus.mem_read_en) overlap++;
            if (in_drain && bus.in_ready) drain_viol++;
            if (cyc == after_last_cyc + 1) check_val("in_ready_after_last", 32'(bus.in_ready), 32'd1);
            if (bus.mem_read_en) begin
                issued++;
                if (!rd_seen) begin rd_seen = 1; first_rd_cyc = cyc; end
            end
            if (bus.out_valid && !ov_seen) begin ov_seen = 1; first_ov_cyc = cyc; end
            if (bus.mem_write_en) begin
                if (exp_wr.size() == 0) check_val("spurious_write", 32'd1, 32'd0);
                else begin
                    e_wr = exp_wr.pop_front();
                    check_val("write", 32'({bus.mem_write_row, bus.mem_write_col, bus.mem_data_in}), 32'(e_wr));
                    if (bus.mem_write_row == AW'(N-1) && bus.mem_write_col == AW'(N-1)) in_drain = 1;
                end
                last_wr_cyc = cyc; rd_seen = 0; ov_seen = 0; out_seen = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                accepted++; out_cnt++;
                $display("out data=%02h last_row=%0b last=%0b", bus.out_data, bus.out_last_row, bus.out_last);
                if (!out_seen) begin out_seen = 1; first_out_cyc = cyc; end
                if (exp_q.size() == 0) check_val("spurious_output", 32'd1, 32'd0);
                else begin
                    e_out = exp_q.pop_front();
                    check_val("out_elem", 32'({bus.out_data, bus.out_last_row, bus.out_last}), 32'(e_out));
                end
                if (bus.out_last) begin
                    last_out_cyc = cyc; after_last_cyc = cyc; done_cnt++; in_drain = 0;
                end
            end
        end
    end

    function automatic logic [31:0] all_outputs();
        return 32'({bus.in_ready, bus.out_valid, bus.out_last_row, bus.out_last,
                    bus.mem_write_en, bus.mem_read_en, bus.mem_write_row, bus.mem_write_col,
                    bus.mem_read_row, bus.mem_read_col, bus.out_data, bus.mem_data_in});
    endfunction

    // Called at a rising edge; feeds one matrix and queues the expected results.
    task automatic send_matrix(input int base, input bit gaps, input bit rnd, input bit xsel);
        logic [DATA_W-1:0] m [N][N];
        out_t o;
        int k = 0;
        int budget = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = rnd ? DATA_W'($urandom) : DATA_W'(base + r*N + c);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                o.d    = xsel ? m[j][i] : m[i][j];
                o.lr   = (j == N-1);
                o.last = (i == N-1) && (j == N-1);
                exp_q.push_back(o);
            end
        for (int n = 0; n < N*N; n++) exp_wr.push_back({AW'(n / N), AW'(n % N), m[n / N][n % N]});
        out_cnt = 0;
`ifdef XPOSE_SELECT_EN
        xpose_sel = xsel;
`endif
        while (k < N*N && budget < 1000) begin
            #1;
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = m[k / N][k % N];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            @(posedge clk);
            budget++;
        end
        check_val("fill_count", 32'(k), 32'(N*N));
    endtask

    // Waits (bounded) for out_last while driving junk input the DUT must ignore.
    task automatic wait_done();
        int target = done_cnt + 1;
        int n = 0;
        while (done_cnt < target && n < 600) begin
            #1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = DATA_W'($urandom);
            @(posedge clk);
            n++;
        end
        check_val("drain_done", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_out(input int cnt);
        int n = 0;
        while (out_cnt < cnt && n < 200) begin @(posedge clk); n++; end
        check_val("wait_out", 32'(out_cnt >= cnt), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin #1; bus.in_valid = 1'b0; @(posedge clk); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state and release timing
        @(posedge clk); #1;
        check_val("reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b1;
        check_val("in_ready_at_release", 32'(bus.in_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check_val("in_ready_second_edge", 32'(bus.in_ready), 32'd1);
        @(posedge clk);

        // Basic transpose, streaming, turnaround latency
        ready_mode = 0;
        send_matrix(8'h00, 0, 0, 1);
        wait_done();
        check_val("stream_span", 32'(last_out_cyc - first_out_cyc), 32'(N*N - 1));
        check_val("first_read_latency", 32'(first_rd_cyc - last_wr_cyc), 32'd1);
        check_val("first_valid_latency", 32'(first_ov_cyc - last_wr_cyc), 32'd2);
        idle(2);

        // Backpressure: forced 5-cycle stall mid-drain, then random ready
        send_matrix(8'h00, 0, 0, 1);
        wait_out(5);
        stall_cnt = 5;
        ready_mode = 1;
        wait_done();
        idle(1);

        // Input gaps
        ready_mode = 0;
        send_matrix(8'h00, 1, 0, 1);
        wait_done();

        // Back-to-back matrices, then random data under random backpressure
        send_matrix(8'h10, 0, 0, 1);
        wait_done();
        ready_mode = 1;
        send_matrix(0, 1, 1, 1);
        wait_done();
        idle(2);
        ready_mode = 0;

`ifdef XPOSE_SELECT_EN
        send_matrix(8'h00, 0, 0, 0);
        wait_done();
        send_matrix(0, 1, 1, 1);
        wait_done();
        idle(2);
`endif

        // Asynchronous reset in the middle of a drain
        send_matrix(0, 0, 1, 1);
        #1 bus.in_valid = 1'b0;
        wait_out(3);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("reset_mid_drain", all_outputs(), 32'd0);
        exp_q.delete();
        exp_wr.delete();
        in_drain = 0; issued = 0; accepted = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("in_ready_at_release2", 32'(bus.in_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check_val("in_ready_second_edge2", 32'(bus.in_ready), 32'd1);
        @(posedge clk);

        // Recovery after reset
        send_matrix(8'h20, 0, 0, 1);
        wait_done();
        idle(3);

        check_val("no_rd_wr_overlap", 32'(overlap), 32'd0);
        check_val("in_ready_low_in_drain", 32'(drain_viol), 32'd0);
        check_val("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
        check_val("expected_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
